// File: rtl/io_seq_pkg.sv
// Shared types and constants for the IO sequencer.
package io_seq_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT_IN  = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_STEP     = 3'd3,
    ST_HALTED   = 3'd4
  } seq_state_t;

  localparam logic [31:0] BLANK_DISPLAY = 32'h07FF_FFFF;

endpackage

// File: rtl/ce_prescaler.sv
// Free-running 0..CE_DIV-1 prescaler; tick marks the last count of each period.
module ce_prescaler #(
  parameter int CE_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CE_DIV - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/io_sequencer.sv
// Steps the CPU via a clock enable and stalls it on IN/OUT/HALT until the user
// presses the button.
//   state       | meaning
//   ST_RUN      | free running, one cpu_en per prescaler tick unless an op is decoded
//   ST_WAIT_IN  | waiting for a press to capture the switches
//   ST_WAIT_OUT | display holds the OUT value, waiting for a press
//   ST_STEP     | released; a full period later the IO instruction executes
//   ST_HALTED   | absorbing until reset
module io_sequencer
  import io_seq_pkg::*;
#(
  parameter int CE_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_in,
  input  logic        op_out,
  input  logic        op_halt,
  input  logic        button,
  input  logic [17:0] switches,
  input  logic [27:0] cpu_data,
  output logic        cpu_en,
  output logic [31:0] in_value,
  output logic [31:0] display_data,
  output logic        display_valid,
  output logic        waiting,
  output logic        halted,
  output logic [15:0] step_count
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic        r_btn_q;
  logic        w_press;
  logic        w_tick;
  logic        w_clear;
  logic        w_cpu_en;
  logic        w_capture_in;
  logic        w_capture_out;
  logic [31:0] r_in_value;
  logic [31:0] r_display_data;
  logic        r_display_valid;
  logic        r_waiting;
  logic        r_halted;
  logic [15:0] r_step_count;

  ce_prescaler #(.CE_DIV(CE_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // A press is a rising edge only, so a button held across a wait entry never releases it.
  assign w_press = button & ~r_btn_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cpu_en      = 1'b0;
    w_clear       = 1'b0;
    w_capture_in  = 1'b0;
    w_capture_out = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_tick) begin
          if (op_halt) begin
            w_state_nxt = ST_HALTED;
          end else if (op_in) begin
            w_state_nxt = ST_WAIT_IN;
          end else if (op_out) begin
            w_state_nxt   = ST_WAIT_OUT;
            w_capture_out = 1'b1;
          end else begin
            w_cpu_en = 1'b1;
          end
        end
      end
      ST_WAIT_IN: begin
        if (w_press) begin
          w_capture_in = 1'b1;
          w_clear      = 1'b1;
          w_state_nxt  = ST_STEP;
        end
      end
      ST_WAIT_OUT: begin
        if (w_press) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (w_tick) begin
          w_cpu_en    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    if (reset) begin
      w_cpu_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_q         <= 1'b0;
      r_in_value      <= '0;
      r_display_data  <= BLANK_DISPLAY;
      r_display_valid <= 1'b0;
      r_waiting       <= 1'b0;
      r_halted        <= 1'b0;
      r_step_count    <= '0;
    end else begin
      r_btn_q <= button;
      if (w_capture_in) begin
        r_in_value <= {14'h0, switches};
      end
      if (w_capture_out) begin
        r_display_data  <= {4'h0, cpu_data};
        r_display_valid <= 1'b1;
      end
      if (w_cpu_en) begin
        r_step_count <= r_step_count + 16'd1;
      end
      r_waiting <= (w_state_nxt == ST_WAIT_IN) || (w_state_nxt == ST_WAIT_OUT);
      r_halted  <= (w_state_nxt == ST_HALTED);
    end
  end

  assign cpu_en        = w_cpu_en;
  assign in_value      = r_in_value;
  assign display_data  = r_display_data;
  assign display_valid = r_display_valid;
  assign waiting       = r_waiting;
  assign halted        = r_halted;
  assign step_count    = r_step_count;

endmodule

// File: tb/tb_io_sequencer.sv
// Self-checking bench for io_sequencer: directed table, directed sequences,
// randomized run against a behavioural model, and a CE_DIV=1 wrap check.
module tb_io_sequencer;

  localparam int CE = 4;
  localparam logic [31:0] BLANK = 32'h07FF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_in = 1'b0, op_out = 1'b0, op_halt = 1'b0, button = 1'b0;
  logic [17:0] switches = '0;
  logic [27:0] cpu_data = '0;

  logic        cpu_en, display_valid, waiting, halted;
  logic [31:0] in_value, display_data;
  logic [15:0] step_count;

  logic        cpu_en_1, display_valid_1, waiting_1, halted_1;
  logic [31:0] in_value_1, display_data_1;
  logic [15:0] step_count_1;

  io_sequencer #(.CE_DIV(CE)) dut (
    .clock(clock), .reset(reset), .op_in(op_in), .op_out(op_out), .op_halt(op_halt),
    .button(button), .switches(switches), .cpu_data(cpu_data), .cpu_en(cpu_en),
    .in_value(in_value), .display_data(display_data), .display_valid(display_valid),
    .waiting(waiting), .halted(halted), .step_count(step_count)
  );

  io_sequencer #(.CE_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .op_in(op_in), .op_out(op_out), .op_halt(op_halt),
    .button(button), .switches(switches), .cpu_data(cpu_data), .cpu_en(cpu_en_1),
    .in_value(in_value_1), .display_data(display_data_1), .display_valid(display_valid_1),
    .waiting(waiting_1), .halted(halted_1), .step_count(step_count_1)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: period position, what the CPU is blocked on, and held outputs.
  int          m_cnt;
  bit          m_halt;
  int          m_wait;      // 0 none, 1 waiting for IN, 2 waiting after OUT
  bit          m_step;
  bit          m_btn_prev;
  logic [31:0] m_in;
  logic [31:0] m_disp;
  bit          m_dv;
  int          m_steps;

  task automatic model_init();
    m_cnt = 0; m_halt = 0; m_wait = 0; m_step = 0; m_btn_prev = 0;
    m_in = '0; m_disp = BLANK; m_dv = 0; m_steps = 0;
  endtask

  function automatic bit m_tick();
    return m_cnt == CE - 1;
  endfunction

  function automatic bit m_cpu_en();
    return !reset && m_tick() && !m_halt && (m_wait == 0) &&
           (m_step || !(op_halt || op_in || op_out));
  endfunction

  task automatic model_advance();
    bit en, tk, press;
    int nc;
    en = m_cpu_en();
    tk = m_tick();
    if (reset) begin
      model_init();
    end else begin
      press = button && !m_btn_prev;
      if (en) m_steps = (m_steps + 1) % 65536;
      nc = tk ? 0 : m_cnt + 1;
      if (!m_halt) begin
        if (m_wait != 0) begin
          if (press) begin
            if (m_wait == 1) m_in = {14'h0, switches};
            m_wait = 0;
            m_step = 1;
            nc = 0;
          end
        end else if (m_step) begin
          if (tk) m_step = 0;
        end else if (tk) begin
          if (op_halt) m_halt = 1;
          else if (op_in) m_wait = 1;
          else if (op_out) begin
            m_wait = 2;
            m_disp = {4'h0, cpu_data};
            m_dv = 1;
          end
        end
      end
      m_btn_prev = button;
      m_cnt = nc;
    end
  endtask

  logic s_cpu_en;

  // Inputs change at posedge+1; outputs are sampled at negedge+1.
  task automatic cycle();
    @(negedge clock);
    #1;
    s_cpu_en = cpu_en;
    check("cpu_en", 32'(cpu_en), 32'(m_cpu_en()));
    check("waiting", 32'(waiting), 32'(m_wait != 0));
    check("halted", 32'(halted), 32'(m_halt));
    check("step_count", 32'(step_count), 32'(m_steps[15:0]));
    check("in_value", in_value, m_in);
    check("display_data", display_data, m_disp);
    check("display_valid", 32'(display_valid), 32'(m_dv));
    @(posedge clock);
    model_advance();
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1; op_in = 0; op_out = 0; op_halt = 0; button = 0;
    repeat (n) @(posedge clock);
    #1;
    reset = 0;
    model_init();
  endtask

  typedef struct {
    logic        op_in, op_out, op_halt, button;
    logic [27:0] data;
    logic        en, wt, vl;
    logic [31:0] disp;
    logic [15:0] steps;
  } vec_t;

  function automatic vec_t row(input logic i, input logic o, input logic h, input logic b,
                               input logic e, input logic w, input logic v,
                               input logic [31:0] d, input logic [15:0] s);
    vec_t r;
    r.op_in = i; r.op_out = o; r.op_halt = h; r.button = b; r.data = 28'hABCDEF1;
    r.en = e; r.wt = w; r.vl = v; r.disp = d; r.steps = s;
    return r;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [11:0] mask12;
    logic [3:0]  mask4;
    int          en_cnt;
    logic [31:0] dd;

    dd = 32'h0ABCDEF1;
    // OUT entry with button held from before entry; release, press, step a period later.
    tbl[0]  = row(0, 1, 0, 1, 0, 0, 0, BLANK, 0);
    tbl[1]  = row(0, 1, 0, 1, 0, 0, 0, BLANK, 0);
    tbl[2]  = row(0, 1, 0, 1, 0, 0, 0, BLANK, 0);
    tbl[3]  = row(0, 1, 0, 1, 0, 0, 0, BLANK, 0);
    tbl[4]  = row(0, 0, 0, 1, 0, 1, 1, dd, 0);
    tbl[5]  = row(0, 0, 0, 1, 0, 1, 1, dd, 0);
    tbl[6]  = row(0, 0, 0, 0, 0, 1, 1, dd, 0);
    tbl[7]  = row(0, 0, 0, 1, 0, 1, 1, dd, 0);
    tbl[8]  = row(0, 0, 0, 1, 0, 0, 1, dd, 0);
    tbl[9]  = row(0, 0, 0, 0, 0, 0, 1, dd, 0);
    tbl[10] = row(0, 1, 0, 0, 0, 0, 1, dd, 0);
    tbl[11] = row(0, 1, 0, 0, 1, 0, 1, dd, 0);
    tbl[12] = row(0, 0, 0, 0, 0, 0, 1, dd, 1);

    // Reset values, and cpu_en low during reset even where tick is always high.
    reset = 1;
    @(posedge clock);
    #1;
    check("rst_cpu_en_div1", 32'(cpu_en_1), 32'd0);
    do_reset(1);
    check("rst_in_value", in_value, 32'd0);
    check("rst_display", display_data, BLANK);
    check("rst_valid", 32'(display_valid), 32'd0);
    check("rst_steps", 32'(step_count), 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      op_in = tbl[i].op_in; op_out = tbl[i].op_out; op_halt = tbl[i].op_halt;
      button = tbl[i].button; cpu_data = tbl[i].data;
      @(negedge clock);
      #1;
      check($sformatf("tbl%0d_cpu_en", i), 32'(cpu_en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_waiting", i), 32'(waiting), 32'(tbl[i].wt));
      check($sformatf("tbl%0d_valid", i), 32'(display_valid), 32'(tbl[i].vl));
      check($sformatf("tbl%0d_display", i), display_data, tbl[i].disp);
      check($sformatf("tbl%0d_steps", i), 32'(step_count), 32'(tbl[i].steps));
      @(posedge clock);
      #1;
    end

    // Free run: pulses on cycles 3, 7, 11.
    do_reset(2);
    mask12 = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      mask12[i] = s_cpu_en;
    end
    check("run_pulses", 32'(mask12), 32'h888);
    check("run_steps", 32'(step_count), 32'd3);

    // IN wait, long stall, press captures switches, step a full period later.
    do_reset(2);
    op_in = 1; switches = 18'h2A5A5;
    repeat (4) cycle();
    en_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (s_cpu_en) en_cnt++;
    end
    check("in_stall_en", 32'(en_cnt), 32'd0);
    check("in_stall_wait", 32'(waiting), 32'd1);
    button = 1;
    cycle();
    button = 0; op_in = 0;
    check("in_capture", in_value, 32'h0002A5A5);
    mask4 = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      mask4[i] = s_cpu_en;
    end
    check("in_release_en", 32'(mask4), 32'h8);
    check("in_release_wait", 32'(waiting), 32'd0);
    check("in_release_steps", 32'(step_count), 32'd1);

    // All ops on a tick: halt wins and absorbs presses.
    do_reset(2);
    op_halt = 1; op_in = 1; op_out = 1; cpu_data = 28'h1111111;
    repeat (4) cycle();
    op_halt = 0; op_in = 0; op_out = 0;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_no_out", 32'(display_valid), 32'd0);
    en_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      button = i[0];
      cycle();
      if (s_cpu_en) en_cnt++;
    end
    button = 0;
    check("halt_en", 32'(en_cnt), 32'd0);
    reset = 1;
    cycle();
    reset = 0;
    check("halt_reset_flag", 32'(halted), 32'd0);
    check("halt_reset_disp", display_data, BLANK);

    // Reset in the middle of an OUT wait.
    do_reset(2);
    repeat (8) cycle();
    op_out = 1; cpu_data = 28'h1234567;
    repeat (4) cycle();
    op_out = 0;
    check("wout_valid", 32'(display_valid), 32'd1);
    check("wout_disp", display_data, 32'h01234567);
    reset = 1;
    cycle();
    reset = 0;
    check("wout_rst_valid", 32'(display_valid), 32'd0);
    check("wout_rst_steps", 32'(step_count), 32'd0);
    check("wout_rst_wait", 32'(waiting), 32'd0);

    // Randomized run against the model.
    do_reset(2);
    for (int i = 0; i < 2500; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      op_halt  = ($urandom_range(0, 399) == 0);
      op_in    = ($urandom_range(0, 5) == 0);
      op_out   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) button = ~button;
      switches = 18'($urandom);
      cpu_data = 28'($urandom);
      cycle();
    end
    reset = 0;

    // CE_DIV=1: 65535 steps preload the counter, the next one wraps it.
    do_reset(2);
    repeat (65535) @(posedge clock);
    #1;
    check("div1_preload", 32'(step_count_1), 32'h0000FFFF);
    check("div1_en", 32'(cpu_en_1), 32'd1);
    @(posedge clock);
    #1;
    check("div1_wrap", 32'(step_count_1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
